stage_id_pipe: RTL

STAGE_ID_PIPE -- requirements
Module: stage_id_pipe

---
 rtl/stage_id_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stage_id_pipe.sv
// Instruction-decode stage with register file and one-entry output register.
//
// Decodes a 32-bit RV32-style instruction, reads two source registers (with
// optional write-back forwarding), builds the sign-extended immediate and
// flags unknown opcodes. A single load-use interlock inserts one bubble when
// the incoming instruction consumes the destination of a load that is still
// held in the output register.
//
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   in_valid/in_ready              fetch handshake; in_instr, in_pc payload
//   wb_regwrite, wb_rd, wb_wd      register-file write port
//   flush                          drop held output, refuse the offered one
//   out_valid/out_ready            downstream handshake
//   id_*                           registered decode results
module stage_id_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_regwrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_rdata1,
  output logic [XLEN-1:0] id_rdata2,
  output logic [RW-1:0]   id_rs1,
  output logic [RW-1:0]   id_rs2,
  output logic [RW-1:0]   id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic            id_is_load,
  output logic            id_illegal
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  logic [XLEN-1:0] rf_q [NREG];

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            illegal, uses_rs1, uses_rs2, is_load;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            hz, accept;

  assign opcode  = in_instr[6:0];
  assign rd      = in_instr[7 +: RW];
  assign rs1     = in_instr[15 +: RW];
  assign rs2     = in_instr[20 +: RW];
  assign is_load = (opcode == OpLoad);
  assign imm_ext = XLEN'($signed(imm32));

  always_comb begin
    imm32    = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpReg: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpImm, OpLoad, OpJalr: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        uses_rs1 = 1'b1;
      end
      OpStore: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpBranch: begin
        imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpLui, OpAuipc: imm32 = {in_instr[31:12], 12'b0};
      OpJal: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
      OpSystem, OpFence: ;
      default: illegal = 1'b1;
    endcase
  end

  // Register read; forwarding presents this cycle's write-back value.
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : rf_q[rs1];
    rdata2 = (rs2 == '0) ? '0 : rf_q[rs2];
    if (BYPASS != 0 && wb_regwrite && rs1 != '0 && wb_rd == rs1) rdata1 = wb_wd;
    if (BYPASS != 0 && wb_regwrite && rs2 != '0 && wb_rd == rs2) rdata2 = wb_wd;
  end

  // Load-use interlock against the load currently held in the output register.
  assign hz = out_valid & id_is_load & (id_rd != '0) &
              ((uses_rs1 & (rs1 == id_rd)) | (uses_rs2 & (rs2 == id_rd)));

  assign in_ready = (!out_valid | out_ready) & !hz & !flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_q <= '{default: '0};
    end else if (wb_regwrite && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      id_pc       <= '0;
      id_imm      <= '0;
      id_rdata1   <= '0;
      id_rdata2   <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_opcode   <= '0;
      id_funct3   <= '0;
      id_funct7b5 <= 1'b0;
      id_is_load  <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      id_pc       <= in_pc;
      id_imm      <= imm_ext;
      id_rdata1   <= rdata1;
      id_rdata2   <= rdata2;
      id_rs1      <= rs1;
      id_rs2      <= rs2;
      id_rd       <= rd;
      id_opcode   <= opcode;
      id_funct3   <= in_instr[14:12];
      id_funct7b5 <= in_instr[30];
      id_is_load  <= is_load;
      id_illegal  <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
